// File: rtl/booth_mult8_stream_ctrl.sv
// booth_mult8_stream_ctrl
//   Stream wrapper around an external multi-cycle multiplier core. Operands
//   queue in a small input FIFO. A two-state controller (IDLE/RUN) launches
//   one operation at a time on the core and collects the product together
//   with its tag into an output FIFO. An operation whose core_done never
//   arrives is aborted after TIMEOUT RUN cycles and flagged on err_timeout.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready                operand handshake
//   in_a, in_b, in_sign, in_tag      multiplicand, multiplier, sign mode, tag
//   core_start                       one-cycle launch pulse to the core
//   core_mcand, core_mplier          operands held for the core
//   core_sign_mode                   [1]=mcand signed, [0]=mplier signed
//   core_product, core_done          result and completion pulse from the core
//   out_valid/out_ready              result handshake
//   out_product, out_tag             head of the output FIFO
//   busy                             an operation is in flight
//   err_timeout, err_clr             sticky abort flag and its clear
module booth_mult8_stream_ctrl #(
   parameter int WIDTH     = 8,
   parameter int TAG_W     = 4,
   parameter int IN_DEPTH  = 2,
   parameter int OUT_DEPTH = 2,
   parameter int TIMEOUT   = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic [1:0]           in_sign,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 core_start,
   output logic [WIDTH-1:0]     core_mcand,
   output logic [WIDTH-1:0]     core_mplier,
   output logic [1:0]           core_sign_mode,
   input  logic [2*WIDTH-1:0]   core_product,
   input  logic                 core_done,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product,
   output logic [TAG_W-1:0]     out_tag,
   output logic                 busy,
   output logic                 err_timeout,
   input  logic                 err_clr
);

   localparam int IW  = 2 + TAG_W + 2*WIDTH;   // {sign, tag, b, a}
   localparam int OW  = TAG_W + 2*WIDTH;       // {tag, product}
   localparam int IPW = (IN_DEPTH  > 1) ? $clog2(IN_DEPTH)  : 1;
   localparam int OPW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int ICW = $clog2(IN_DEPTH + 1);
   localparam int OCW = $clog2(OUT_DEPTH + 1);
   localparam int CTW = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   // ---------------- input FIFO ----------------
   logic [IW-1:0]  in_mem_q [IN_DEPTH];
   logic [IPW-1:0] in_wr_q, in_rd_q;
   logic [ICW-1:0] in_cnt_q, in_cnt_d;
   logic           in_push, in_pop, in_empty, in_full;
   logic [IW-1:0]  in_head;
   logic           in_ready_en_q;   // keeps in_ready low while in reset

   // ---------------- output FIFO ----------------
   logic [OW-1:0]  out_mem_q [OUT_DEPTH];
   logic [OPW-1:0] out_wr_q, out_rd_q;
   logic [OCW-1:0] out_cnt_q, out_cnt_d;
   logic           out_push, out_pop, out_empty, out_full;
   logic [OW-1:0]  out_head;

   // ---------------- controller ----------------
   state_t             state_q;
   logic [CTW-1:0]     run_cnt_q;
   logic               core_start_q;
   logic [WIDTH-1:0]   mcand_q, mplier_q;
   logic [1:0]         sign_q;
   logic [TAG_W-1:0]   tag_q;
   logic               err_q;
   logic               launch, done_hit, timeout_hit;

   assign in_empty = (in_cnt_q == '0);
   assign in_full  = (in_cnt_q == ICW'(IN_DEPTH));
   assign in_head  = in_mem_q[in_rd_q];
   // in_ready depends only on registers, never on in_valid.
   assign in_ready = in_ready_en_q & ~in_full;
   assign in_push  = in_valid & in_ready;

   assign out_empty = (out_cnt_q == '0);
   assign out_full  = (out_cnt_q == OCW'(OUT_DEPTH));
   assign out_head  = out_mem_q[out_rd_q];
   assign out_valid = ~out_empty;
   assign out_pop   = out_valid & out_ready;

   // Free space is judged before any same-cycle pop, so a completing
   // operation always finds room in the output FIFO.
   assign launch      = (state_q == IDLE) & ~in_empty & ~out_full;
   assign in_pop      = launch;
   assign done_hit    = (state_q == RUN) & core_done;
   assign timeout_hit = (state_q == RUN) & ~core_done & (run_cnt_q == CTW'(TIMEOUT - 1));
   assign out_push    = done_hit;

   always_comb begin
      in_cnt_d = in_cnt_q;
      if (in_push & ~in_pop)      in_cnt_d = in_cnt_q + ICW'(1);
      else if (~in_push & in_pop) in_cnt_d = in_cnt_q - ICW'(1);
      out_cnt_d = out_cnt_q;
      if (out_push & ~out_pop)      out_cnt_d = out_cnt_q + OCW'(1);
      else if (~out_push & out_pop) out_cnt_d = out_cnt_q - OCW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < IN_DEPTH; i++) in_mem_q[i] <= '0;
         in_wr_q       <= '0;
         in_rd_q       <= '0;
         in_cnt_q      <= '0;
         in_ready_en_q <= 1'b0;
      end else begin
         in_ready_en_q <= 1'b1;
         if (in_push) begin
            in_mem_q[in_wr_q] <= {in_sign, in_tag, in_b, in_a};
            in_wr_q <= (in_wr_q == IPW'(IN_DEPTH - 1)) ? '0 : in_wr_q + IPW'(1);
         end
         if (in_pop)
            in_rd_q <= (in_rd_q == IPW'(IN_DEPTH - 1)) ? '0 : in_rd_q + IPW'(1);
         in_cnt_q <= in_cnt_d;
      end
   end

   // Memory is cleared on reset so out_product/out_tag read as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < OUT_DEPTH; i++) out_mem_q[i] <= '0;
         out_wr_q  <= '0;
         out_rd_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         if (out_push) begin
            out_mem_q[out_wr_q] <= {tag_q, core_product};
            out_wr_q <= (out_wr_q == OPW'(OUT_DEPTH - 1)) ? '0 : out_wr_q + OPW'(1);
         end
         if (out_pop)
            out_rd_q <= (out_rd_q == OPW'(OUT_DEPTH - 1)) ? '0 : out_rd_q + OPW'(1);
         out_cnt_q <= out_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         run_cnt_q    <= '0;
         core_start_q <= 1'b0;
         mcand_q      <= '0;
         mplier_q     <= '0;
         sign_q       <= '0;
         tag_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         core_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // core_done seen here belongs to nothing and is dropped.
               if (launch) begin
                  state_q      <= RUN;
                  run_cnt_q    <= '0;
                  core_start_q <= 1'b1;
                  mcand_q      <= in_head[WIDTH-1:0];
                  mplier_q     <= in_head[2*WIDTH-1:WIDTH];
                  tag_q        <= in_head[2*WIDTH+TAG_W-1:2*WIDTH];
                  sign_q       <= in_head[IW-1:IW-2];
               end
            end
            RUN: begin
               if (done_hit || timeout_hit) state_q <= IDLE;
               else                         run_cnt_q <= run_cnt_q + CTW'(1);
            end
            default: state_q <= IDLE;
         endcase
         // A timeout wins over a simultaneous clear.
         if (timeout_hit)  err_q <= 1'b1;
         else if (err_clr) err_q <= 1'b0;
      end
   end

   assign core_start     = core_start_q;
   assign core_mcand     = mcand_q;
   assign core_mplier    = mplier_q;
   assign core_sign_mode = sign_q;
   assign out_product    = out_head[2*WIDTH-1:0];
   assign out_tag        = out_head[OW-1:2*WIDTH];
   assign busy           = (state_q == RUN) | core_start_q;
   assign err_timeout    = err_q;

endmodule

// File: tb/tb_booth_mult8_stream_ctrl.sv
// tb_booth_mult8_stream_ctrl
//   Self-checking bench for booth_mult8_stream_ctrl. A behavioural core model
//   answers each sampled core_start with core_done six cycles later carrying
//   the signed/unsigned product. Expected results come from plain arithmetic
//   on the operands driven at the input port.
module tb_booth_mult8_stream_ctrl;

   localparam int CORE_D = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_a = '0, in_b = '0;
   logic [1:0]  in_sign = '0;
   logic [3:0]  in_tag = '0;
   logic        core_start;
   logic [7:0]  core_mcand, core_mplier;
   logic [1:0]  core_sign_mode;
   logic [15:0] core_product = '0;
   logic        core_done = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_product;
   logic [3:0]  out_tag;
   logic        busy, err_timeout;
   logic        err_clr = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;

   booth_mult8_stream_ctrl #(
      .WIDTH(8), .TAG_W(4), .IN_DEPTH(2), .OUT_DEPTH(2), .TIMEOUT(15)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sign(in_sign), .in_tag(in_tag),
      .core_start(core_start), .core_mcand(core_mcand), .core_mplier(core_mplier),
      .core_sign_mode(core_sign_mode), .core_product(core_product), .core_done(core_done),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_product(out_product), .out_tag(out_tag),
      .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_mult(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] s);
      longint ea, eb;
      ea = s[1] ? longint'($signed(a)) : longint'(a);
      eb = s[0] ? longint'($signed(b)) : longint'(b);
      return 16'(ea * eb);
   endfunction

   // ---------------- behavioural multiplier core ----------------
   logic core_hang = 1'b0;     // when set, a start is swallowed and never answered
   int   core_cnt = 0;
   int   start_count = 0;
   int   overlap_viol = 0;

   always @(posedge clk) begin
      core_done <= 1'b0;
      if (core_cnt == 1) core_done <= 1'b1;
      if (core_cnt > 0)  core_cnt <= core_cnt - 1;
      if (core_start) begin
         start_count <= start_count + 1;
         if (core_cnt > 1) overlap_viol <= overlap_viol + 1;
         if (!core_hang) begin
            core_cnt     <= CORE_D;
            core_product <= ref_mult(core_mcand, core_mplier, core_sign_mode);
         end
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      tests_run++; if (core_start !== 1'b0) begin tests_failed++; $display("FAIL reset_core_start got=%b exp=0", core_start); end
      tests_run++; if ({core_mcand, core_mplier, core_sign_mode} !== 18'h0) begin tests_failed++; $display("FAIL reset_core_ops got=%h exp=0", {core_mcand, core_mplier, core_sign_mode}); end
      tests_run++; if ({out_product, out_tag} !== 20'h0) begin tests_failed++; $display("FAIL reset_out_data got=%h exp=0", {out_product, out_tag}); end
      tests_run++; if ({busy, err_timeout} !== 2'b00) begin tests_failed++; $display("FAIL reset_busy_err got=%b exp=00", {busy, err_timeout}); end
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_single();
      int first_valid = -1;
      int starts = 0;
      logic [7:0] mc = '0;
      @(negedge clk);
      out_ready = 1'b0;
      in_a = 8'hFD; in_b = 8'h05; in_sign = 2'b11; in_tag = 4'd3; in_valid = 1'b1;
      @(posedge clk);   // handshake edge
      #1 in_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (core_start) begin starts++; mc = core_mcand; end
         if (out_valid && first_valid < 0) first_valid = k;
      end
      tests_run++; if (starts !== 1) begin tests_failed++; $display("FAIL single_start_pulses got=%0d exp=1", starts); end
      tests_run++; if (mc !== 8'hFD) begin tests_failed++; $display("FAIL single_mcand got=%h exp=fd", mc); end
      tests_run++; if (core_mcand !== 8'hFD || core_mplier !== 8'h05) begin tests_failed++; $display("FAIL single_ops_hold got=%h/%h exp=fd/05", core_mcand, core_mplier); end
      tests_run++; if (first_valid !== 9) begin tests_failed++; $display("FAIL single_latency got=%0d exp=9", first_valid); end
      tests_run++; if (out_product !== 16'hFFF1) begin tests_failed++; $display("FAIL single_product got=%h exp=fff1", out_product); end
      tests_run++; if (out_tag !== 4'd3) begin tests_failed++; $display("FAIL single_tag got=%0d exp=3", out_tag); end
      $display("[TB] txn single tag=%0d product=%h", out_tag, out_product);
      @(negedge clk); out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0;
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_drained got=%b exp=0", out_valid); end
   endtask

   // Stimulus helper only: pushes one operand set and returns the result.
   task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                          input logic [3:0] t, output logic [15:0] prod,
                          output logic [3:0] tg, output logic ok);
      logic accepted;
      ok = 1'b0; prod = '0; tg = '0;
      @(negedge clk);
      out_ready = 1'b0;
      in_a = a; in_b = b; in_sign = s; in_tag = t; in_valid = 1'b1;
      for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
      accepted = in_ready;
      @(negedge clk); in_valid = 1'b0;
      if (accepted) begin
         for (int i = 0; i < 40; i++) begin
            if (out_valid) begin prod = out_product; tg = out_tag; ok = 1'b1; break; end
            @(negedge clk);
         end
      end
      out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0;
      $display("[TB] txn a=%h b=%h sign=%b tag=%0d product=%h", a, b, s, tg, prod);
   endtask

   task automatic test_ff();
      logic [15:0] p; logic [3:0] t; logic ok;
      run_one(8'hFF, 8'hFF, 2'b00, 4'd7, p, t, ok);
      tests_run++; if (ok !== 1'b1 || p !== 16'hFE01 || t !== 4'd7) begin tests_failed++; $display("FAIL ff_unsigned got=%h tag=%0d ok=%b exp=fe01 tag=7", p, t, ok); end
      run_one(8'hFF, 8'hFF, 2'b11, 4'd8, p, t, ok);
      tests_run++; if (ok !== 1'b1 || p !== 16'h0001 || t !== 4'd8) begin tests_failed++; $display("FAIL ff_signed got=%h tag=%0d ok=%b exp=0001 tag=8", p, t, ok); end
      run_one(8'h80, 8'hFF, 2'b10, 4'd9, p, t, ok);
      tests_run++; if (ok !== 1'b1 || p !== ref_mult(8'h80, 8'hFF, 2'b10)) begin tests_failed++; $display("FAIL mixed_sign got=%h exp=%h", p, ref_mult(8'h80, 8'hFF, 2'b10)); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ba [5];
      logic [7:0] bb [5];
      logic [1:0] bs [5];
      int idx = 0, got = 0, s0;
      for (int i = 0; i < 5; i++) begin
         ba[i] = 8'($urandom); bb[i] = 8'($urandom); bs[i] = 2'($urandom);
      end
      s0 = start_count;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (c == 45) begin
            tests_run++; if (idx !== 4) begin tests_failed++; $display("FAIL b2b_accepted got=%0d exp=4", idx); end
            tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_in_ready got=%b exp=0", in_ready); end
            tests_run++; if (start_count - s0 !== 2) begin tests_failed++; $display("FAIL b2b_starts_held got=%0d exp=2", start_count - s0); end
            tests_run++; if (out_valid !== 1'b1 || out_tag !== 4'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_hold got valid=%b tag=%0d busy=%b exp 1/0/0", out_valid, out_tag, busy); end
         end
         out_ready = (c >= 50);
         if (out_valid && out_ready) begin
            tests_run++;
            if (got >= 5 || out_tag !== 4'(got) || out_product !== ref_mult(ba[got], bb[got], bs[got])) begin
               tests_failed++;
               $display("FAIL b2b_result got tag=%0d product=%h exp tag=%0d", out_tag, out_product, got);
            end
            $display("[TB] txn b2b tag=%0d product=%h", out_tag, out_product);
            got++;
         end
         if (idx < 5) begin
            in_a = ba[idx]; in_b = bb[idx]; in_sign = bs[idx]; in_tag = 4'(idx); in_valid = 1'b1;
            if (in_ready) idx++;
         end else begin
            in_valid = 1'b0;
         end
         if (got == 5 && idx == 5) break;
      end
      @(negedge clk); out_ready = 1'b0; in_valid = 1'b0;
      tests_run++; if (got !== 5) begin tests_failed++; $display("FAIL b2b_count got=%0d exp=5", got); end
   endtask

   task automatic test_timeout();
      int first_start = -1, second_start = -1, outs = 0;
      logic [3:0] otag = '0; logic [15:0] oprod = '0;
      core_hang = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (core_start) begin
            if (first_start < 0) first_start = c;
            else if (second_start < 0) second_start = c;
         end
         if (first_start >= 0 && c == first_start + 2) core_hang = 1'b0;
         if (first_start >= 0 && c == first_start + 14) begin
            tests_run++; if (err_timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_early got=%b exp=0", err_timeout); end
         end
         if (first_start >= 0 && c == first_start + 15) begin
            tests_run++; if (err_timeout !== 1'b1) begin tests_failed++; $display("FAIL timeout_flag got=%b exp=1", err_timeout); end
         end
         if (out_valid) begin outs++; otag = out_tag; oprod = out_product; end
         if (c == 0) begin in_a = 8'h12; in_b = 8'h34; in_sign = 2'b00; in_tag = 4'd5; in_valid = 1'b1; end
         else if (c == 1) begin
            tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL timeout_in_ready got=%b exp=1", in_ready); end
            in_a = 8'h9C; in_b = 8'h07; in_sign = 2'b10; in_tag = 4'd6; in_valid = 1'b1;
         end
         else in_valid = 1'b0;
      end
      core_hang = 1'b0;
      $display("[TB] txn timeout tag=%0d product=%h outs=%0d", otag, oprod, outs);
      tests_run++; if (second_start - first_start !== 16) begin tests_failed++; $display("FAIL timeout_next_launch got=%0d exp=16", second_start - first_start); end
      tests_run++; if (outs !== 1 || otag !== 4'd6 || oprod !== ref_mult(8'h9C, 8'h07, 2'b10)) begin tests_failed++; $display("FAIL timeout_output got outs=%0d tag=%0d product=%h exp 1/6/%h", outs, otag, oprod, ref_mult(8'h9C, 8'h07, 2'b10)); end
      tests_run++; if (err_timeout !== 1'b1) begin tests_failed++; $display("FAIL timeout_sticky got=%b exp=1", err_timeout); end
      err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0; out_ready = 1'b0;
      tests_run++; if (err_timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_clear got=%b exp=0", err_timeout); end
   endtask

   task automatic test_reset_mid_run();
      int late_valid = 0, late_start = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c <= 2) begin
            in_a = 8'($urandom) | 8'h01; in_b = 8'($urandom) | 8'h01; in_sign = 2'b01;
            in_tag = 4'(c + 1); in_valid = 1'b1;
         end else in_valid = 1'b0;
         if (c == 4) begin
            tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_busy got=%b exp=1", busy); end
         end
         if (c == 5) rst_n = 1'b0;
         if (c == 6) begin
            tests_run++; if ({in_ready, out_valid, core_start, busy, err_timeout} !== 5'b0) begin tests_failed++; $display("FAIL rst_mid_flags got=%b exp=00000", {in_ready, out_valid, core_start, busy, err_timeout}); end
            tests_run++; if ({core_mcand, core_mplier, core_sign_mode, out_product, out_tag} !== 38'h0) begin tests_failed++; $display("FAIL rst_mid_data got=%h exp=0", {core_mcand, core_mplier, core_sign_mode, out_product, out_tag}); end
         end
         if (c == 7) rst_n = 1'b1;
         if (c >= 8) begin
            out_ready = 1'b1;
            if (out_valid) late_valid++;
            if (core_start) late_start++;
         end
         if (c == 10) begin
            tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
         end
      end
      out_ready = 1'b0;
      tests_run++; if (late_valid !== 0 || late_start !== 0) begin tests_failed++; $display("FAIL rst_mid_discard got valid=%0d start=%0d exp 0/0", late_valid, late_start); end
   endtask

   task automatic test_random();
      localparam int N = 1000;
      logic [19:0] exp_q [$];
      logic [19:0] e;
      int sent = 0, rcv = 0;
      logic acc = 1'b0;
      logic hold = 1'b0;
      logic [19:0] held = '0;
      logic [7:0] a, b; logic [1:0] s; logic [3:0] t;
      for (int c = 0; c < 40000; c++) begin
         @(negedge clk);
         if (hold) begin
            tests_run++;
            if (out_valid !== 1'b1 || {out_tag, out_product} !== held) begin
               tests_failed++;
               $display("FAIL rand_stable got=%b/%h exp=1/%h", out_valid, {out_tag, out_product}, held);
            end
         end
         if (acc) begin in_valid = 1'b0; acc = 1'b0; end
         if (!in_valid && sent < N && $urandom_range(3) != 0) begin
            a = 8'($urandom); b = 8'($urandom); s = 2'($urandom); t = 4'($urandom);
            in_a = a; in_b = b; in_sign = s; in_tag = t; in_valid = 1'b1;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back({in_tag, ref_mult(in_a, in_b, in_sign)});
            sent++; acc = 1'b1;
         end
         out_ready = ($urandom_range(2) != 0);
         hold = out_valid && !out_ready;
         held = {out_tag, out_product};
         if (out_valid && out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL rand_extra got=%h exp=none", {out_tag, out_product});
            end else begin
               e = exp_q.pop_front();
               if ({out_tag, out_product} !== e) begin
                  tests_failed++;
                  $display("FAIL rand_result n=%0d got=%h exp=%h", rcv, {out_tag, out_product}, e);
               end
            end
            $display("[TB] txn rand n=%0d tag=%0d product=%h", rcv, out_tag, out_product);
            rcv++;
         end
         if (rcv == N) break;
      end
      @(negedge clk); out_ready = 1'b0; in_valid = 1'b0;
      tests_run++; if (rcv !== N || sent !== N) begin tests_failed++; $display("FAIL rand_count got sent=%0d rcv=%0d exp=%0d", sent, rcv, N); end
      tests_run++; if (overlap_viol !== 0) begin tests_failed++; $display("FAIL rand_overlap got=%0d exp=0", overlap_viol); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_ff();
      test_back_to_back();
      test_timeout();
      test_reset_mid_run();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/booth_mult8_stream_ctrl.md
BOOTH_MULT8_STREAM_CTRL -- requirements
Module: booth_mult8_stream_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): WIDTH, 8, operand width; TAG_W, 4, transaction tag width; IN_DEPTH, 2, input FIFO entries; OUT_DEPTH, 2, output FIFO entries; TIMEOUT, 15, max RUN cycles before abort.
REQ-002 Ports SHALL be (name  direction  width  meaning): clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 in_valid in 1 / in_ready out 1 SHALL form the operand handshake; in_a in WIDTH multiplicand; in_b in WIDTH multiplier; in_sign in 2 sign_mode ([1]=a signed, [0]=b signed); in_tag in TAG_W user tag.
REQ-004 core_start out 1 one-cycle start pulse; core_mcand out WIDTH; core_mplier out WIDTH; core_sign_mode out 2; core_product in 2*WIDTH; core_done in 1 completion pulse from the multiplier core.
REQ-005 out_valid out 1 / out_ready in 1 SHALL form the result handshake; out_product out 2*WIDTH; out_tag out TAG_W.
REQ-006 busy out 1 high while an operation is in flight; err_timeout out 1 sticky abort flag; err_clr in 1 synchronous clear of err_timeout.

Function
REQ-007 Input transfer SHALL occur on a clock edge with in_valid & in_ready; in_ready = input FIFO not full; no combinational path from in_valid to in_ready.
REQ-008 Output transfer SHALL occur on an edge with out_valid & out_ready; out_valid = output FIFO not empty; out_product/out_tag = FIFO head, stable while out_valid & !out_ready.
REQ-009 Both FIFOs SHALL be in-order, pointer-based, wrap modulo depth, and support simultaneous push and pop in one cycle, including push to a full FIFO with concurrent pop (in_ready stays low when full; push occurs only via the handshake).
REQ-010 The FSM SHALL have states IDLE and RUN; reset state IDLE.
REQ-011 IDLE -> RUN when input FIFO non-empty AND output FIFO has at least one free entry (counted before any same-cycle pop); on that edge the FIFO head is popped, core_mcand/core_mplier/core_sign_mode/tag are registered from it, and core_start registers to 1.
REQ-012 core_start SHALL be high for exactly one cycle; core operand outputs SHALL hold their value until the next launch.
REQ-013 In RUN, core_done sampled high SHALL push {core_product, tag} into the output FIFO on that edge and return the FSM to IDLE; free space is guaranteed by REQ-011.
REQ-014 A RUN cycle counter SHALL reset to 0 on entering RUN and increment each RUN cycle; if it reaches TIMEOUT without core_done, the FSM SHALL return to IDLE, discard the operation (no push), and set err_timeout.
REQ-015 core_done while in IDLE SHALL be ignored.
REQ-016 At most one operation SHALL be outstanding at the core; busy = (state == RUN) | core_start.
REQ-017 err_timeout SHALL clear on err_clr; a timeout in the same cycle as err_clr SHALL leave err_timeout set.
REQ-018 Products SHALL pass unmodified; this block performs no arithmetic on data.
REQ-019 With empty FIFOs, a core asserting core_done D cycles after sampling core_start, and out_ready=1, out_valid SHALL rise D+3 cycles after the input handshake edge.

Reset
REQ-020 On rst_n low: FSM IDLE, both FIFOs empty, counter 0; in_ready=0 while in reset and 1 after release; out_valid=0, core_start=0, core operand outputs 0, out_product=0, out_tag=0, busy=0, err_timeout=0.
REQ-021 Reset mid-RUN SHALL discard all queued and in-flight operations; a core_done arriving after reset release SHALL be ignored per REQ-015.

Verification (bench core model: core_done pulses 6 cycles after sampling core_start, product = signed/unsigned product per sign_mode)
REQ-022 a=0xFD, b=0x05, sign=2'b11, tag=3 -> one core_start pulse with mcand 0xFD; out_product=0xFFF1, out_tag=3, out_valid high 9 cycles after the input handshake.
REQ-023 a=0xFF, b=0xFF, sign=2'b00 -> out_product=0xFE01; sign=2'b11 -> out_product=0x0001.
REQ-024 Back-to-back 5 inputs, tags 0..4, out_ready=0 -> in_ready drops after the FIFOs fill, exactly 2 results held, no core_start while output FIFO full; release out_ready -> tags 0..4 emerge in order, none lost.
REQ-025 Core model never asserts core_done -> after TIMEOUT=15 RUN cycles err_timeout=1, no output, next queued operation launches; err_clr -> err_timeout=0.
REQ-026 rst_n pulsed low during RUN with 2 queued inputs -> all outputs at reset values; late core_done produces no out_valid.
REQ-027 Random valid/ready stall patterns over 1000 operations -> scoreboard match of products and tags, in order, no duplicates.
